parking_gate_monitor: RTL and testbench

//  Multi-lane successor to the single-lane car-park entry/exit detector: N_LANES independent
//  two-sensor (a,b) sequence FSMs plus a shared saturating occupancy counter. Per lane it flags

---
 rtl/parking_gate_monitor.sv | 154 +++++++++++++++
 tb/tb_parking_gate_monitor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/parking_gate_monitor.sv
// Multi-lane car-park gate monitor: one a/b sequence FSM per lane plus a
// shared saturating occupancy counter driven by the lanes' completion events.

// Per-lane a/b sequence detector with a dwell-timeout.
module parking_gate_lane #(
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    output logic enter_evt,
    output logic exit_evt,
    output logic abort_evt
);
    typedef enum logic [2:0] {IDLE, EN1, EN2, EN3, EX1, EX2, EX3} state_t;

    state_t            state, state_next, fwd, bwd;
    logic [1:0]        p, own, nxt, prv;
    logic [TMO_W-1:0]  timer;

    // State register and dwell timer; timer restarts on any state change and idles at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || state == IDLE) timer <= '0;
            else                                      timer <= timer + 1'b1;
        end
    end

    // Each non-IDLE state is described by its own/next/previous pattern and its
    // forward/backward neighbours, so a single rule set covers both paths.
    always_comb begin
        p          = {a, b};
        state_next = state;
        enter_evt  = 1'b0;
        exit_evt   = 1'b0;
        abort_evt  = 1'b0;
        own = 2'b00; nxt = 2'b00; prv = 2'b00; fwd = IDLE; bwd = IDLE;
        case (state)
            EN1: begin own = 2'b10; nxt = 2'b11; prv = 2'b00; fwd = EN2;  bwd = IDLE; end
            EN2: begin own = 2'b11; nxt = 2'b01; prv = 2'b10; fwd = EN3;  bwd = EN1;  end
            EN3: begin own = 2'b01; nxt = 2'b00; prv = 2'b11; fwd = IDLE; bwd = EN2;  end
            EX1: begin own = 2'b01; nxt = 2'b11; prv = 2'b00; fwd = EX2;  bwd = IDLE; end
            EX2: begin own = 2'b11; nxt = 2'b10; prv = 2'b01; fwd = EX3;  bwd = EX1;  end
            EX3: begin own = 2'b10; nxt = 2'b00; prv = 2'b11; fwd = IDLE; bwd = EX2;  end
            default: ;
        endcase
        if (state == IDLE) begin
            if      (p == 2'b10) state_next = EN1;
            else if (p == 2'b01) state_next = EX1;
        end else if (p == own) begin
            // Hold, unless this is the last permitted cycle of residency.
            if (timer == TMO_W'(TIMEOUT - 1)) begin
                state_next = IDLE;
                abort_evt  = 1'b1;
            end
        end else if (p == nxt) begin
            state_next = fwd;
            enter_evt  = (state == EN3);
            exit_evt   = (state == EX3);
        end else if (p == prv) begin
            state_next = bwd;
        end else begin
            state_next = IDLE;
            abort_evt  = 1'b1;
        end
    end
endmodule

module parking_gate_monitor #(
    parameter int N_LANES = 2,
    parameter int CAP     = 16,
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] a,
    input  logic [N_LANES-1:0] b,
    output logic [N_LANES-1:0] enter,
    output logic [N_LANES-1:0] exit,
    output logic [N_LANES-1:0] abort,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               ovf,
    output logic               udf
);
    // Wide enough to hold count + N_LANES and -N_LANES without wrapping.
    localparam int SW = CNT_W + $clog2(N_LANES) + 1;
    localparam logic signed [SW-1:0] CAP_S = SW'(CAP);

    logic [N_LANES-1:0]     enter_evt, exit_evt, abort_evt;
    logic signed [SW-1:0]   sum;
    logic [CNT_W-1:0]       count_next;
    logic                   ovf_next, udf_next;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        parking_gate_lane #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) u_lane (
            .clk       (clk),
            .reset     (reset),
            .a         (a[i]),
            .b         (b[i]),
            .enter_evt (enter_evt[i]),
            .exit_evt  (exit_evt[i]),
            .abort_evt (abort_evt[i])
        );
    end

    // Net occupancy change this cycle, clamped to 0..CAP with clip flags.
    always_comb begin
        sum = SW'(count);
        for (int i = 0; i < N_LANES; i++)
            sum = sum + SW'(enter_evt[i]) - SW'(exit_evt[i]);
        count_next = sum[CNT_W-1:0];
        ovf_next   = 1'b0;
        udf_next   = 1'b0;
        if (sum[SW-1]) begin
            count_next = '0;
            udf_next   = 1'b1;
        end else if (sum > CAP_S) begin
            count_next = CNT_W'(CAP);
            ovf_next   = 1'b1;
        end
    end

    // Registered pulses and counter share one edge so count and pulses align.
    always_ff @(posedge clk) begin
        if (reset) begin
            enter <= '0;
            exit  <= '0;
            abort <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            enter <= enter_evt;
            exit  <= exit_evt;
            abort <= abort_evt;
            count <= count_next;
            ovf   <= ovf_next;
            udf   <= udf_next;
        end
    end

    assign full  = (count == CNT_W'(CAP));
    assign empty = (count == '0);
endmodule

// File: tb/tb_parking_gate_monitor.sv
// Directed bench for parking_gate_monitor: a vector table for single-step
// sequences plus hand-written multi-cycle corner cases.
module tb_parking_gate_monitor;
    localparam int N = 2, CAP = 16, CNT_W = 5, TIMEOUT = 255, TMO_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     a, b, en, ex, ab;
    logic [CNT_W-1:0] count;
    logic             full, empty, ovf, udf;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_cnt;

    parking_gate_monitor #(.N_LANES(N), .CAP(CAP), .CNT_W(CNT_W),
                           .TIMEOUT(TIMEOUT), .TMO_W(TMO_W)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .enter(en), .exit(ex), .abort(ab),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic [1:0] a, b, en, ex, ab;
        int         cnt;
        logic       ud;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic [1:0] ai, bi, e_en, e_ex, e_ab,
                                int cnt, logic ud);
        vec_t v;
        v.nm = nm; v.a = ai; v.b = bi; v.en = e_en; v.ex = e_ex; v.ab = e_ab;
        v.cnt = cnt; v.ud = ud;
        return v;
    endfunction

    // Drive inputs, let one edge sample them, then settle past the edge.
    task automatic step(input logic [1:0] ai, input logic [1:0] bi);
        a = ai; b = bi;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] e_en, e_ex, e_ab,
                       input int e_cnt, input logic e_ov, e_ud);
        logic e_full, e_empty;
        e_full  = (e_cnt == CAP);
        e_empty = (e_cnt == 0);
        n_chk++;
        if ({en, ex, ab, count, full, empty, ovf, udf} ===
            {e_en, e_ex, e_ab, CNT_W'(e_cnt), e_full, e_empty, e_ov, e_ud})
            n_pass++;
        else
            $display("FAIL %s: got en=%b ex=%b ab=%b cnt=%0d full=%b empty=%b ovf=%b udf=%b | want en=%b ex=%b ab=%b cnt=%0d full=%b empty=%b ovf=%b udf=%b",
                     nm, en, ex, ab, count, full, empty, ovf, udf,
                     e_en, e_ex, e_ab, e_cnt, e_full, e_empty, e_ov, e_ud);
    endtask

    // Quick lane-0 entry, checking only the completion cycle.
    task automatic entry0();
        step(2'b01, 2'b00); step(2'b01, 2'b01); step(2'b00, 2'b01); step(2'b00, 2'b00);
        exp_cnt++;
        chk("fill_entry", 2'b01, 2'b00, 2'b00, exp_cnt, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; a = '0; b = '0;
        step(2'b00, 2'b00); step(2'b00, 2'b00);
        chk("reset_state", 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0);
        reset = 1'b0;

        // lane0 p = {a[0],b[0]}, lane1 p = {a[1],b[1]}
        tbl.push_back(mk("idle_11",     2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("idle_00",     2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("t1_10",       2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("t1_11",       2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("t1_01",       2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("t1_enter",    2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("t1_after",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("t2_01",       2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("t2_11",       2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("t2_10",       2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("t2_exit",     2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1'b0));
        tbl.push_back(mk("t2_after",    2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("rev_10",      2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("rev_11",      2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("rev_back10",  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("rev_11b",     2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("rev_01",      2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("rev_enter",   2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("t4_10",       2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("t4_abort",    2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 1, 1'b0));
        tbl.push_back(mk("ex1_back00",  2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("dn_01",       2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("dn_11",       2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("dn_10",       2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1'b0));
        tbl.push_back(mk("dn_exit",     2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1'b0));
        tbl.push_back(mk("udf_01",      2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("udf_11",      2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("udf_10",      2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("udf_exit",    2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 0, 1'b1));
        tbl.push_back(mk("udf_after",   2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("mix0_a",      2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("mix0_b",      2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("mix0_c",      2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1'b0));
        tbl.push_back(mk("mix0_done",   2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 0, 1'b0));

        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].b);
            chk(tbl[i].nm, tbl[i].en, tbl[i].ex, tbl[i].ab, tbl[i].cnt, 1'b0, tbl[i].ud);
        end
        exp_cnt = 0;

        // T3: every pattern held 5 cycles, then one enter.
        for (int i = 0; i < 5; i++) begin step(2'b01, 2'b00); chk("t3_hold10", 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0); end
        for (int i = 0; i < 5; i++) begin step(2'b01, 2'b01); chk("t3_hold11", 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0); end
        for (int i = 0; i < 5; i++) begin step(2'b00, 2'b01); chk("t3_hold01", 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0); end
        step(2'b00, 2'b00); exp_cnt = 1;
        chk("t3_enter", 2'b01, 2'b00, 2'b00, exp_cnt, 1'b0, 1'b0);
        step(2'b00, 2'b00);
        chk("t3_single", 2'b00, 2'b00, 2'b00, exp_cnt, 1'b0, 1'b0);

        // T4: park in EN2; the first 11 sample enters EN2, residency then lasts TIMEOUT samples.
        step(2'b01, 2'b00);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            step(2'b01, 2'b01);
            if (k == TIMEOUT)     chk("tmo_last_hold", 2'b00, 2'b00, 2'b00, exp_cnt, 1'b0, 1'b0);
            if (k == TIMEOUT + 1) chk("tmo_abort",     2'b00, 2'b00, 2'b01, exp_cnt, 1'b0, 1'b0);
        end
        step(2'b01, 2'b01);
        chk("tmo_idle11", 2'b00, 2'b00, 2'b00, exp_cnt, 1'b0, 1'b0);
        step(2'b00, 2'b00);

        // T5: fill to CAP-1, then a double entry clips at CAP.
        while (exp_cnt < CAP - 1) entry0();
        step(2'b11, 2'b00); step(2'b11, 2'b11); step(2'b00, 2'b11); step(2'b00, 2'b00);
        exp_cnt = CAP;
        chk("t5_dual_ovf", 2'b11, 2'b00, 2'b00, exp_cnt, 1'b1, 1'b0);
        step(2'b00, 2'b00);
        chk("t5_full_hold", 2'b00, 2'b00, 2'b00, exp_cnt, 1'b0, 1'b0);
        step(2'b01, 2'b00); step(2'b01, 2'b01); step(2'b00, 2'b01); step(2'b00, 2'b00);
        chk("t5_full_ovf", 2'b01, 2'b00, 2'b00, exp_cnt, 1'b1, 1'b0);
        step(2'b01, 2'b10); step(2'b11, 2'b11); step(2'b10, 2'b01); step(2'b00, 2'b00);
        chk("t5_mix_full", 2'b01, 2'b10, 2'b00, exp_cnt, 1'b0, 1'b0);
        step(2'b00, 2'b10); step(2'b10, 2'b10); step(2'b10, 2'b00); step(2'b00, 2'b00);
        exp_cnt = CAP - 1;
        chk("t5_leave_full", 2'b00, 2'b10, 2'b00, exp_cnt, 1'b0, 1'b0);

        // T6: reset while lane0 sits in EN3 discards the sequence.
        step(2'b01, 2'b00); step(2'b01, 2'b01); step(2'b00, 2'b01);
        reset = 1'b1;
        step(2'b00, 2'b01);
        chk("t6_reset", 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0);
        reset = 1'b0;
        step(2'b00, 2'b00);
        chk("t6_no_enter", 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0);
        step(2'b00, 2'b00);
        chk("t6_quiet", 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
